riot_input_conditioner: RTL
===========================

# riot_input_conditioner

Front-end conditioner for the RIOT's port inputs. Takes raw, asynchronous, bouncy joystick and console-switch contacts, synchronises and debounces them, and drives the RIOT `PAin`/`PBin` buses with the bit map and polarity the 7800 system software expects. It sits directly upstream of RIOT. Its outputs feed `PAin`/`PBin` unmodified, so RIOT's PA7 edge detector only ever sees clean, single transitions.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchroniser; minimum 2.
- `TICK_DIV`, default 1193: CLK cycles per debounce sample tick (≈1 ms at 1.19 MHz).
- `DEBOUNCE_SAMPLES`, default 4: consecutive disagreeing ticks required to flip a stable bit; minimum 1.
- `CLK` in 1: system clock; all state updates on the rising edge.
- `RES_n` in 1: asynchronous active-low reset.
- `joy0` in 4: player 0 raw contacts {right, left, down, up}, 1 = pressed.
- `joy1` in 4: player 1 raw contacts, same order.
- `sw_reset`, `sw_select`, `sw_pause` in 1 each: console buttons, 1 = pressed.
- `diff_l`, `diff_r` in 1 each: difficulty switches, 1 = A position.
- `bypass` in 1: 1 = skip debounce; outputs follow the synchronised inputs.
- `PAin` out 8: to RIOT port A input.
- `PBin` out 8: to RIOT port B input.
- `changed` out 1: one-cycle pulse when any output bit changes.

## Operation
- Output bit map:
  - `PAin[7:4]` = ~joy0 {right, left, down, up}.
  - `PAin[3:0]` = ~joy1 {right, left, down, up}.
  - `PBin[0]` = ~sw_reset, `PBin[1]` = ~sw_select, `PBin[3]` = ~sw_pause.
  - `PBin[6]` = diff_l, `PBin[7]` = diff_r.
  - `PBin[2]`, `PBin[4]`, `PBin[5]` are constant 1.
- Reset values, applied asynchronously: `PAin`=8'hFF, `PBin`=8'h3F, `changed`=0. All synchroniser flops, stable bits and debounce counters are cleared to the released/B state. The tick divider is loaded with TICK_DIV-1.
- 13 conditioned bits total. Each bit passes through a SYNC_STAGES flop chain, then its own debouncer.
- Tick divider: counts down each cycle. `tick` is asserted in the cycle where the divider equals 0, and the divider reloads TICK_DIV-1 in that same cycle. The first tick after reset release occurs at cycle TICK_DIV-1.
- Debouncer, per bit, evaluated only on tick cycles:
  - If the synchronised value equals the stable value, the counter clears to 0.
  - If it differs and counter == DEBOUNCE_SAMPLES-1, the stable value flips and the counter clears.
  - If it differs otherwise, the counter increments.
  - Counter width is clog2(DEBOUNCE_SAMPLES) with a minimum of 1. It never wraps: the flip clears it.
- A single agreeing tick discards all accumulated count (bounce rejection).
- `bypass`=1: each stable value loads its synchronised value every cycle and every counter is held at 0. Deasserting `bypass` resumes debouncing from the current stable values, with no output glitch.
- `PAin`/`PBin` are registered images of the stable values after the bit map is applied.
- `changed` is registered. It is 1 in the cycle the outputs take a new value, and only if at least one bit differs from the previous cycle. Several bits flipping on the same tick produce a single pulse.

## Timing
- Raw-to-synchronised latency: SYNC_STAGES cycles.
- Debounced latency from a clean raw edge: SYNC_STAGES cycles, plus the wait to the next tick, plus (DEBOUNCE_SAMPLES-1)·TICK_DIV, plus 1 output-register cycle.
  - Minimum: SYNC_STAGES + (DEBOUNCE_SAMPLES-1)·TICK_DIV + 1.
  - Maximum: that value plus TICK_DIV-1.
- Bypass latency: SYNC_STAGES + 1 cycles.
- Outputs change only on a rising CLK edge, and never more than once per tick except in bypass.
- Reset asserted mid-count: outputs return to their reset values immediately (asynchronously). Counters and tick phase restart; no partial count survives.

## Structure
- Package `riot_input_pkg` holds:
  - Bit-index constants: PA_P0_RIGHT..PA_P1_UP, PB_RESET, PB_SELECT, PB_PAUSE, PB_DIFF_L, PB_DIFF_R.
  - `PA_RESET_VAL`=8'hFF and `PB_RESET_VAL`=8'h3F.
  - The mask of unused PB bits.
- One sub-module, `debounce_bit`, containing the synchroniser chain, counter and stable flop, with parameters SYNC_STAGES and DEBOUNCE_SAMPLES. It has inputs `tick` and `bypass` and output `stable`. It is instantiated 13 times.
- The tick divider, bit mapping, output registers and `changed` logic live in the top level.

## Test plan
Bench parameters: SYNC_STAGES=2, TICK_DIV=4, DEBOUNCE_SAMPLES=3.
- **Reset:** RES_n low, all raw inputs 0 → `PAin`=8'hFF, `PBin`=8'h3F, `changed`=0, also while CLK is stopped.
- **Clean press:** joy0 up held at 1 → `PAin` becomes 8'hEF between cycle 2+8+1 and cycle 2+8+4 after the edge, with exactly one `changed` pulse. Release → returns to 8'hFF.
- **Bounce:** sw_pause at 1 for 2 ticks, then 0 → `PBin` stays 8'h3F and `changed` never pulses. A subsequent 3-tick hold → `PBin`=8'h37.
- **Simultaneous:** diff_l and joy1 right go to 1 in the same cycle → `PBin`=8'h7F and `PAin`=8'hF7 on the same edge, with a single `changed` pulse.
- **Reset mid-count:** press joy0 left, pulse RES_n low after 2 ticks → outputs stay 8'hFF/8'h3F. The full 3-tick count is required after release.
- **Bypass:** bypass=1, joy0 left to 1 → `PAin`=8'hBF exactly 3 cycles later, with `changed` pulsed. Drop bypass while held → no output change.

Source files
------------

// File: rtl/riot_input_pkg.sv
// Shared constants and port-image mapping for the RIOT input conditioner.
// Raw vector: bits [7:0] mirror PAin positions, bits [12:8] are console switches.
package riot_input_pkg;

  localparam int NUM_BITS = 13;

  localparam int PA_P0_RIGHT = 7;
  localparam int PA_P0_LEFT  = 6;
  localparam int PA_P0_DOWN  = 5;
  localparam int PA_P0_UP    = 4;
  localparam int PA_P1_RIGHT = 3;
  localparam int PA_P1_LEFT  = 2;
  localparam int PA_P1_DOWN  = 1;
  localparam int PA_P1_UP    = 0;

  localparam int PB_RESET  = 0;
  localparam int PB_SELECT = 1;
  localparam int PB_PAUSE  = 3;
  localparam int PB_DIFF_L = 6;
  localparam int PB_DIFF_R = 7;

  localparam logic [7:0] PA_RESET_VAL   = 8'hFF;
  localparam logic [7:0] PB_RESET_VAL   = 8'h3F;
  localparam logic [7:0] PB_UNUSED_MASK = 8'h34;

  localparam int RAW_RESET  = 8;
  localparam int RAW_SELECT = 9;
  localparam int RAW_PAUSE  = 10;
  localparam int RAW_DIFF_L = 11;
  localparam int RAW_DIFF_R = 12;

  typedef struct packed {
    logic [7:0] pa;
    logic [7:0] pb;
  } port_img_t;

  // Contacts are 1 = pressed; RIOT expects active-low buttons, difficulty as-is.
  function automatic port_img_t map_ports(input logic [NUM_BITS-1:0] s);
    port_img_t img;
    img.pa            = ~s[7:0];
    img.pb            = PB_UNUSED_MASK;
    img.pb[PB_RESET]  = ~s[RAW_RESET];
    img.pb[PB_SELECT] = ~s[RAW_SELECT];
    img.pb[PB_PAUSE]  = ~s[RAW_PAUSE];
    img.pb[PB_DIFF_L] = s[RAW_DIFF_L];
    img.pb[PB_DIFF_R] = s[RAW_DIFF_R];
    return img;
  endfunction

endpackage

// File: rtl/riot_input_conditioner_debounce_bit.sv
// One conditioned contact: synchroniser chain, tick-gated debounce counter, stable flop.
// stable_nxt lets the top register its port image on the same edge the bit flips.
module debounce_bit #(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic CLK,
  input  logic RES_n,
  input  logic raw,
  input  logic tick,
  input  logic bypass,
  output logic stable,
  output logic stable_nxt
);

  localparam int CW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SAMPLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_stable;
  logic                   w_stable_nxt;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Any agreeing tick throws away the partial count, so bounces never accumulate.
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = r_cnt;
    if (bypass) begin
      w_stable_nxt = w_sync;
      w_cnt_nxt    = '0;
    end else if (tick) begin
      if (w_sync == r_stable) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == CNT_LAST) begin
        w_stable_nxt = ~r_stable;
        w_cnt_nxt    = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RES_n) begin
    if (!RES_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], raw};
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
    end
  end

  assign stable     = r_stable;
  assign stable_nxt = w_stable_nxt;

endmodule

// File: rtl/riot_input_conditioner.sv
// Joystick/console-switch front end for RIOT: sync, debounce, remap to PAin/PBin.
// One shared tick divider paces all 13 debouncers so every bit is sampled in lockstep.
module riot_input_conditioner
  import riot_input_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int TICK_DIV         = 1193,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       CLK,
  input  logic       RES_n,
  input  logic [3:0] joy0,
  input  logic [3:0] joy1,
  input  logic       sw_reset,
  input  logic       sw_select,
  input  logic       sw_pause,
  input  logic       diff_l,
  input  logic       diff_r,
  input  logic       bypass,
  output logic [7:0] PAin,
  output logic [7:0] PBin,
  output logic       changed
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0]       r_div;
  logic                w_tick;
  logic [NUM_BITS-1:0] w_raw;
  logic [NUM_BITS-1:0] w_stable;
  logic [NUM_BITS-1:0] w_stable_nxt;
  port_img_t           w_img_cur;
  port_img_t           w_img_nxt;
  logic [7:0]          r_pa;
  logic [7:0]          r_pb;
  logic                r_changed;

  assign w_tick = (r_div == '0);

  always_ff @(posedge CLK or negedge RES_n) begin
    if (!RES_n)      r_div <= DIV_LAST;
    else if (w_tick) r_div <= DIV_LAST;
    else             r_div <= r_div - 1'b1;
  end

  always_comb begin
    w_raw              = '0;
    w_raw[PA_P0_RIGHT] = joy0[3];
    w_raw[PA_P0_LEFT]  = joy0[2];
    w_raw[PA_P0_DOWN]  = joy0[1];
    w_raw[PA_P0_UP]    = joy0[0];
    w_raw[PA_P1_RIGHT] = joy1[3];
    w_raw[PA_P1_LEFT]  = joy1[2];
    w_raw[PA_P1_DOWN]  = joy1[1];
    w_raw[PA_P1_UP]    = joy1[0];
    w_raw[RAW_RESET]   = sw_reset;
    w_raw[RAW_SELECT]  = sw_select;
    w_raw[RAW_PAUSE]   = sw_pause;
    w_raw[RAW_DIFF_L]  = diff_l;
    w_raw[RAW_DIFF_R]  = diff_r;
  end

  for (genvar g = 0; g < NUM_BITS; g++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_db (
      .CLK       (CLK),
      .RES_n     (RES_n),
      .raw       (w_raw[g]),
      .tick      (w_tick),
      .bypass    (bypass),
      .stable    (w_stable[g]),
      .stable_nxt(w_stable_nxt[g])
    );
  end

  assign w_img_cur = map_ports(w_stable);
  assign w_img_nxt = map_ports(w_stable_nxt);

  // Outputs load the next stable image, so they move on the same edge as the flip.
  always_ff @(posedge CLK or negedge RES_n) begin
    if (!RES_n) begin
      r_pa      <= PA_RESET_VAL;
      r_pb      <= PB_RESET_VAL;
      r_changed <= 1'b0;
    end else begin
      r_pa      <= w_img_nxt.pa;
      r_pb      <= w_img_nxt.pb;
      r_changed <= (w_img_nxt != w_img_cur);
    end
  end

  assign PAin    = r_pa;
  assign PBin    = r_pb;
  assign changed = r_changed;

endmodule
